// File: rtl/linear_layer_ctrl.sv
// linear_layer_ctrl
//   Sequencer for a 3-neuron linear output layer. Activations arrive one at a
//   time over a valid/ready handshake. The shared weight ROM is addressed with
//   the index of the activation being accepted. The ROM answers one cycle later
//   with the weights for all three neurons (banks at stride N_IN). The block
//   accumulates three dot products and reports the argmax class.
//
//   Ports
//     clk, rst_n         clock (rising edge), asynchronous active-low reset
//     start              begin an inference; only sampled in IDLE
//     x_valid/x_data     activation stream
//     x_ready            high while in LOAD
//     rom_addr           registered weight ROM address (bank 0 offset)
//     weight1..3         ROM data for neurons 0..2, one cycle after rom_addr
//     busy               high whenever not IDLE
//     done               one-cycle pulse when acc1..3 / class_id are final
//     acc1..3            dot products, held until the next accepted start
//     class_id           index of the largest accumulator; ties go to the lowest index
module linear_layer_ctrl #(
    parameter int unsigned N_IN   = 96,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned W_W    = 3,
    parameter int unsigned X_W    = 8,
    parameter int unsigned ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              x_valid,
    input  logic [X_W-1:0]    x_data,
    output logic              x_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [W_W-1:0]    weight1,
    input  logic [W_W-1:0]    weight2,
    input  logic [W_W-1:0]    weight3,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  acc1,
    output logic [ACC_W-1:0]  acc2,
    output logic [ACC_W-1:0]  acc3,
    output logic [1:0]        class_id
);

    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        CMP   = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] idx;
    logic [X_W-1:0]   x_d;
    logic             vld_d;
    logic             accept;
    logic             last;
    logic [1:0]       argmax;

    assign accept = x_valid & x_ready;
    assign last   = (idx == IDX_W'(N_IN - 1));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        x_ready    = 1'b0;
        case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD: begin
                x_ready = 1'b1;
                if (accept && last) next_state = DRAIN;
            end
            DRAIN: next_state = CMP;
            CMP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ties resolve toward the lower index because each test uses >=.
    always_comb begin
        if (acc1 >= acc2 && acc1 >= acc3) begin
            argmax = 2'd0;
        end else if (acc2 >= acc3) begin
            argmax = 2'd1;
        end else begin
            argmax = 2'd2;
        end
    end

    // x_d/vld_d delay the accepted activation by one cycle so that it meets the
    // ROM data for the address presented in the accept cycle. On a stall,
    // rom_addr holds and vld_d drops, so no product is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            idx      <= '0;
            x_d      <= '0;
            vld_d    <= 1'b0;
            acc1     <= '0;
            acc2     <= '0;
            acc3     <= '0;
            class_id <= '0;
            done     <= 1'b0;
        end else begin
            done  <= 1'b0;
            vld_d <= 1'b0;
            if (vld_d) begin
                acc1 <= acc1 + ACC_W'(x_d) * ACC_W'(weight1);
                acc2 <= acc2 + ACC_W'(x_d) * ACC_W'(weight2);
                acc3 <= acc3 + ACC_W'(x_d) * ACC_W'(weight3);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc1     <= '0;
                        acc2     <= '0;
                        acc3     <= '0;
                        idx      <= '0;
                        rom_addr <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        x_d   <= x_data;
                        vld_d <= 1'b1;
                        if (!last) begin
                            idx      <= idx + IDX_W'(1);
                            rom_addr <= ADDR_W'(idx) + ADDR_W'(1);
                        end
                    end
                end
                CMP: begin
                    class_id <= argmax;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
